// File: rtl/rca_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder.
// rca_beat_t describes one operand beat at the default 32-bit width.
package rca_pkg;

    localparam int MAX_STAGES = 64;
    localparam int BEAT_W     = 32;

    typedef struct packed {
        logic [BEAT_W-1:0] a;
        logic [BEAT_W-1:0] b;
        logic              cin;
        logic              sub;
    } rca_beat_t;

    // Bits rippled per stage; a zero stage count is caught by the top's config check.
    function automatic int lane_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    // Full adder cell, returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/rca_slice.sv
// L-bit combinational ripple slice built from full-adder cells.
// Also exposes the carry into its MSB so the top slice can form signed overflow.
module rca_slice
    import rca_pkg::*;
#(
    parameter int L = 8
) (
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic         cin,
    output logic [L-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [L:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < L; gi++) begin : g_bit
        assign {c[gi+1], sum[gi]} = full_add(a[gi], b[gi], c[gi]);
    end

    assign cout     = c[L];
    assign c_msb_in = c[L-1];

endmodule

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder: stage k ripples slice k, carrying skewed operands forward.
// Optional macro RCA_SUB_EN adds a per-beat sub input (a - b as a + ~b + 1).
module rca_pipe_adder
    import rca_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L = lane_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > MAX_STAGES || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("rca_pipe_adder: WIDTH must be a multiple of STAGES, with STAGES in 1..MAX_STAGES");
    end

    logic sub_eff;
`ifdef RCA_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] rdy;

    // Ready ripples back from the output so bubbles collapse in a single cycle.
    always_comb begin
        vin = '0;
        rdy = '0;
        v_d = v_q;
        vin[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = v_q[k-1];
        end
        rdy[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = rdy[k] ? vin[k] : v_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = gi * L;
        localparam int HI = LO + L;

        logic [WIDTH-1:LO] a_in;
        logic [WIDTH-1:LO] b_in;
        logic              c_in;
        logic [L-1:0]      s_slice;
        logic              c_out;
        logic              c_msb;
        logic [HI-1:0]     s_d;
        logic [HI-1:0]     s_q;
        logic              c_q;
        logic              load;

        assign load = rdy[gi] && vin[gi];

        // Subtraction is folded in at entry, so later stages only ever add.
        if (gi == 0) begin : g_src
            assign a_in = a;
            assign b_in = b ^ {WIDTH{sub_eff}};
            assign c_in = cin || sub_eff;
            assign s_d  = s_slice;
        end else begin : g_src
            assign a_in = g_stage[gi-1].g_skew.a_q;
            assign b_in = g_stage[gi-1].g_skew.b_q;
            assign c_in = g_stage[gi-1].c_q;
            assign s_d  = {s_slice, g_stage[gi-1].s_q};
        end

        rca_slice #(
            .L(L)
        ) u_slice (
            .a        (a_in[LO +: L]),
            .b        (b_in[LO +: L]),
            .cin      (c_in),
            .sum      (s_slice),
            .cout     (c_out),
            .c_msb_in (c_msb)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (load) begin
                s_q <= s_d;
                c_q <= c_out;
            end
        end

        if (gi < STAGES - 1) begin : g_skew
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;
            logic              msb_carry_unused;

            assign msb_carry_unused = c_msb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= a_in[WIDTH-1:HI];
                    b_q <= b_in[WIDTH-1:HI];
                end
            end
        end else begin : g_out
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (load) begin
                    ovf_q <= c_msb ^ c_out;
                end
            end

            assign sum  = s_q;
            assign cout = c_q;
            assign ovf  = ovf_q;
        end
    end

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Self-checking bench for rca_pipe_adder: directed scenarios on a 4-stage 32-bit instance,
// plus a random scoreboard run shared with 1-stage and 32-stage instances.
module tb_rca_pipe_adder;
    import rca_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [2:0]   dut_in_ready;
    logic [2:0]   dut_out_valid;
    logic [2:0]   dut_out_ready;
    logic [2:0]   dut_cout;
    logic [2:0]   dut_ovf;
    logic [W-1:0] dut_sum [3];

    int n_checks = 0;
    int n_errors = 0;

    logic [33:0] sb_mem [3][256];
    int          sb_wr  [3];
    int          sb_rd  [3];

    rca_pipe_adder #(.WIDTH(W), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready[0]),
        .a(a), .b(b), .cin(cin),
`ifdef RCA_SUB_EN
        .sub(sub),
`endif
        .out_valid(dut_out_valid[0]), .out_ready(dut_out_ready[0]),
        .sum(dut_sum[0]), .cout(dut_cout[0]), .ovf(dut_ovf[0])
    );

    rca_pipe_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready[1]),
        .a(a), .b(b), .cin(cin),
`ifdef RCA_SUB_EN
        .sub(sub),
`endif
        .out_valid(dut_out_valid[1]), .out_ready(dut_out_ready[1]),
        .sum(dut_sum[1]), .cout(dut_cout[1]), .ovf(dut_ovf[1])
    );

    rca_pipe_adder #(.WIDTH(W), .STAGES(W)) u_sw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready[2]),
        .a(a), .b(b), .cin(cin),
`ifdef RCA_SUB_EN
        .sub(sub),
`endif
        .out_valid(dut_out_valid[2]), .out_ready(dut_out_ready[2]),
        .sum(dut_sum[2]), .cout(dut_cout[2]), .ovf(dut_ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from the arithmetic definition.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        logic [31:0] yy;
        logic        cc;
        logic [32:0] r;
        logic        o;
        yy = s ? ~y : y;
        cc = s ? 1'b1 : ci;
        r  = {1'b0, x} + {1'b0, yy} + {32'b0, cc};
        o  = (x[31] == yy[31]) && (r[31] != x[31]);
        return {o, r[32], r[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input rca_beat_t bt);
        in_valid = v;
        a        = bt.a;
        b        = bt.b;
        cin      = bt.cin;
        sub      = bt.sub;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, '{32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0});
        dut_out_ready = 3'b111;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (dut_out_valid[0] !== 1'b0 || dut_sum[0] !== 32'h0 || dut_cout[0] !== 1'b0 || dut_ovf[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset[%0d]: got valid=%b sum=%h cout=%b ovf=%b, want all zero",
                         c, dut_out_valid[0], dut_sum[0], dut_cout[0], dut_ovf[0]);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (dut_in_ready[0] !== 1'b1 || dut_out_valid[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", dut_in_ready[0], dut_out_valid[0]);
        end else begin
            $display("reset: released, in_ready=1");
        end
    endtask

    task automatic test_stream();
        rca_beat_t   vec   [8];
        logic [33:0] exp_v [8];
        rca_beat_t   idle;
        vec = '{'{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0},
                '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0},
                '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0},
                '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0},
                '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0},
                '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0},
                '{32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0},
                '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0}};
        exp_v = '{{1'b0, 1'b1, 32'h0000_0000},
                  {1'b1, 1'b0, 32'h8000_0000},
                  {1'b0, 1'b0, 32'h2345_678A},
                  {1'b1, 1'b1, 32'h0000_0000},
                  {1'b0, 1'b0, 32'h0001_0000},
                  {1'b0, 1'b1, 32'hFFFF_FFFF},
                  {1'b1, 1'b0, 32'h8000_0000},
                  {1'b0, 1'b0, 32'h0100_0100}};
        idle = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0};
        dut_out_ready = 3'b111;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive(1'b1, vec[c]);
            else       drive(1'b0, idle);
            tick();
            if (c >= 3) begin
                n_checks++;
                if (dut_out_valid[0] !== 1'b1 || {dut_ovf[0], dut_cout[0], dut_sum[0]} !== exp_v[c-3]) begin
                    n_errors++;
                    $display("FAIL stream[%0d]: got valid=%b ovf=%b cout=%b sum=%h, want valid=1 {ovf,cout,sum}=%h",
                             c - 3, dut_out_valid[0], dut_ovf[0], dut_cout[0], dut_sum[0], exp_v[c-3]);
                end else begin
                    $display("stream[%0d]: sum=%h cout=%b ovf=%b", c - 3, dut_sum[0], dut_cout[0], dut_ovf[0]);
                end
            end
        end
        tick();
        n_checks++;
        if (dut_out_valid[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_tail: got out_valid=%b, want 0", dut_out_valid[0]);
        end
    endtask

    task automatic test_back_to_back();
        rca_beat_t   vec   [6];
        logic [33:0] exp_v [6];
        int          sent;
        int          rcv;
        sent = 0;
        rcv  = 0;
        for (int i = 0; i < 6; i++) begin
            vec[i].a   = 32'h1111_1111 * (i + 1);
            vec[i].b   = 32'h0FFF_FFF0 + i;
            vec[i].cin = 1'(i & 1);
            vec[i].sub = 1'b0;
            exp_v[i]   = model(vec[i].a, vec[i].b, vec[i].cin, 1'b0);
        end
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            dut_out_ready[0] = (c >= 7);
            if (sent < 6) drive(1'b1, vec[sent]);
            else          drive(1'b0, vec[0]);
            if (dut_out_valid[0] && !dut_out_ready[0]) begin
                n_checks++;
                if ({dut_ovf[0], dut_cout[0], dut_sum[0]} !== exp_v[0]) begin
                    n_errors++;
                    $display("FAIL stall_hold[%0d]: got %h, want %h", c, {dut_ovf[0], dut_cout[0], dut_sum[0]}, exp_v[0]);
                end
            end
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                n_checks++;
                if (dut_in_ready[0] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL full_in_ready[%0d]: got %b, want 0", c, dut_in_ready[0]);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (sent != 4) begin
                    n_errors++;
                    $display("FAIL full_accept_count: got %0d, want 4", sent);
                end
            end
            if (dut_out_valid[0] && dut_out_ready[0]) begin
                n_checks++;
                if ({dut_ovf[0], dut_cout[0], dut_sum[0]} !== exp_v[rcv]) begin
                    n_errors++;
                    $display("FAIL drain[%0d]: got %h, want %h", rcv, {dut_ovf[0], dut_cout[0], dut_sum[0]}, exp_v[rcv]);
                end else begin
                    $display("drain[%0d]: sum=%h cout=%b ovf=%b", rcv, dut_sum[0], dut_cout[0], dut_ovf[0]);
                end
                rcv++;
            end
            if (in_valid && dut_in_ready[0]) sent++;
            tick();
        end
        drive(1'b0, vec[0]);
        n_checks++;
        if (rcv != 6) begin
            n_errors++;
            $display("FAIL drain_count: got %0d, want 6", rcv);
        end
    endtask

    task automatic test_bubbles();
        logic [2:0] pat;
        rca_beat_t  junk;
        pat  = 3'b101;
        junk = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
        dut_out_ready = 3'b111;
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      drive(1'b1, '{32'h0, 32'h0, 1'b1, 1'b0});
            else if (c == 2) drive(1'b1, '{32'h3, 32'h4, 1'b0, 1'b0});
            else             drive(1'b0, junk);
            tick();
            if (c >= 3) begin
                n_checks++;
                if (dut_out_valid[0] !== pat[c-3]) begin
                    n_errors++;
                    $display("FAIL bubble_valid[%0d]: got %b, want %b", c - 3, dut_out_valid[0], pat[c-3]);
                end else if (pat[c-3]) begin
                    n_checks++;
                    if (dut_sum[0] !== ((c == 3) ? 32'h1 : 32'h7)) begin
                        n_errors++;
                        $display("FAIL bubble_sum[%0d]: got %h, want %h", c - 3, dut_sum[0], (c == 3) ? 32'h1 : 32'h7);
                    end else begin
                        $display("bubble[%0d]: sum=%h", c - 3, dut_sum[0]);
                    end
                end
            end
        end
    endtask

    task automatic test_midflight_reset();
        dut_out_ready = 3'b111;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, '{32'h1000 + c, 32'h20, 1'b0, 1'b0});
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (dut_out_valid[0] !== 1'b0 || dut_sum[0] !== 32'h0) begin
                n_errors++;
                $display("FAIL flush[%0d]: got valid=%b sum=%h, want 0/0", c, dut_out_valid[0], dut_sum[0]);
            end
            tick();
        end
        drive(1'b1, '{32'h1, 32'h2, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (dut_out_valid[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_early: got out_valid=%b one cycle early, want 0", dut_out_valid[0]);
        end
        tick();
        n_checks++;
        if (dut_out_valid[0] !== 1'b1 || dut_sum[0] !== 32'h3) begin
            n_errors++;
            $display("FAIL post_reset_beat: got valid=%b sum=%h, want 1/00000003", dut_out_valid[0], dut_sum[0]);
        end else begin
            $display("post_reset_beat: sum=%h", dut_sum[0]);
        end
        tick();
    endtask

`ifdef RCA_SUB_EN
    task automatic test_sub();
        rca_beat_t   vec   [4];
        logic [33:0] exp_v [4];
        vec = '{'{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1},
                '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1},
                '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1},
                '{32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0}};
        exp_v = '{{1'b0, 1'b0, 32'hFFFF_FFFE},
                  {1'b0, 1'b1, 32'h0000_0002},
                  {1'b1, 1'b1, 32'h7FFF_FFFF},
                  {1'b0, 1'b0, 32'h0000_0008}};
        dut_out_ready = 3'b111;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1'b1, vec[c]);
            else       drive(1'b0, vec[0]);
            tick();
            if (c >= 3) begin
                n_checks++;
                if (dut_out_valid[0] !== 1'b1 || {dut_ovf[0], dut_cout[0], dut_sum[0]} !== exp_v[c-3]) begin
                    n_errors++;
                    $display("FAIL sub[%0d]: got valid=%b ovf=%b cout=%b sum=%h, want {ovf,cout,sum}=%h",
                             c - 3, dut_out_valid[0], dut_ovf[0], dut_cout[0], dut_sum[0], exp_v[c-3]);
                end else begin
                    $display("sub[%0d]: sum=%h cout=%b ovf=%b", c - 3, dut_sum[0], dut_cout[0], dut_ovf[0]);
                end
            end
        end
        sub = 1'b0;
    endtask
`endif

    task automatic test_random_params();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sb_wr[k] = 0;
            sb_rd[k] = 0;
        end
        for (int c = 0; c < 460; c++) begin
            if (c < 400) begin
                in_valid = ($urandom_range(0, 4) != 0);
                a        = $urandom;
                b        = $urandom;
                cin      = 1'($urandom_range(0, 1));
`ifdef RCA_SUB_EN
                sub      = ($urandom_range(0, 3) == 0);
`else
                sub      = 1'b0;
`endif
            end else begin
                in_valid = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                dut_out_ready[k] = (c >= 400) || ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (dut_out_valid[k] && dut_out_ready[k]) begin
                    n_checks++;
                    if (sb_rd[k] == sb_wr[k]) begin
                        n_errors++;
                        $display("FAIL rand_extra[%0d]: got unexpected beat sum=%h, want none", k, dut_sum[k]);
                    end else begin
                        if ({dut_ovf[k], dut_cout[k], dut_sum[k]} !== sb_mem[k][sb_rd[k][7:0]]) begin
                            n_errors++;
                            $display("FAIL rand[%0d] #%0d: got %h, want %h", k, sb_rd[k],
                                     {dut_ovf[k], dut_cout[k], dut_sum[k]}, sb_mem[k][sb_rd[k][7:0]]);
                        end else begin
                            $display("rand[%0d] #%0d: sum=%h cout=%b ovf=%b", k, sb_rd[k], dut_sum[k], dut_cout[k], dut_ovf[k]);
                        end
                        sb_rd[k]++;
                    end
                end
                if (in_valid && dut_in_ready[k]) begin
                    sb_mem[k][sb_wr[k][7:0]] = model(a, b, cin, sub);
                    sb_wr[k]++;
                end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (sb_rd[k] != sb_wr[k] || sb_wr[k] == 0) begin
                n_errors++;
                $display("FAIL rand_count[%0d]: got %0d results, want %0d (nonzero)", k, sb_rd[k], sb_wr[k]);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        a             = '0;
        b             = '0;
        cin           = 1'b0;
        sub           = 1'b0;
        dut_out_ready = 3'b111;
        test_reset();
        test_stream();
        test_back_to_back();
        test_bubbles();
        test_midflight_reset();
`ifdef RCA_SUB_EN
        test_sub();
`endif
        test_random_params();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
